// File: rtl/msg_receiver.sv
// msg_receiver: recovers a 5-bit message from the transmitter's serial line,
// in NRZ or Manchester coding, with a one-cycle valid or frame_err strobe.
//
// state | meaning
// IDLE  | waiting for a rising edge on the synchronised line
// START | checking the start bit at mid-bit; a low sample is a glitch
// DATA  | recovering five data bits, MSB first
// STOP  | checking the stop bit at mid-bit, then strobing the result
module msg_receiver #(
  parameter int BASE_CYCLES = 16,
  parameter int CW          = $clog2(BASE_CYCLES * 128)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       in,
  input  logic [2:0] PL,
  input  logic       Mode,
  output logic [4:0] Msg,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nx;

  logic          s_meta, s, s_d;
  logic [CW-1:0] cnt;
  logic [2:0]    pl_q;
  logic          mode_q;
  logic [2:0]    bitidx;
  logic [4:0]    sh;
  logic          h1;

  logic [CW:0]   t_full;
  logic [CW-1:0] t_last, t_half, t_qtr, t_3qtr;
  logic          at_last, at_half, at_qtr, at_3qtr;

  logic start_det, h1_en, shift_en, shift_bit, bit_dec, msg_load, err_set;

  // Bit period for the latched PL and the phase points sampled within it.
  // T is a power of two, so the low CW bits of T minus one give T-1 even at PL=7.
  always_comb begin
    t_full  = (CW+1)'(BASE_CYCLES) << pl_q;
    t_last  = t_full[CW-1:0] - CW'(1);
    t_half  = t_full[CW:1];
    t_qtr   = {1'b0, t_full[CW:2]};
    t_3qtr  = t_half + t_qtr;
    at_last = (cnt == t_last);
    at_half = (cnt == t_half);
    at_qtr  = (cnt == t_qtr);
    at_3qtr = (cnt == t_3qtr);
  end

  // Two-flop synchroniser plus one delay stage for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
      s_d    <= 1'b0;
    end else if (init) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
      s_d    <= 1'b0;
    end else begin
      s_meta <= in;
      s      <= s_meta;
      s_d    <= s;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state <= IDLE;
    else if (init) state <= IDLE;
    else           state <= state_nx;
  end

  // Next state and per-cycle datapath controls
  always_comb begin
    state_nx  = state;
    start_det = 1'b0;
    h1_en     = 1'b0;
    shift_en  = 1'b0;
    shift_bit = s;
    bit_dec   = 1'b0;
    msg_load  = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (s && !s_d) begin
          state_nx  = START;
          start_det = 1'b1;
        end
      end
      START: begin
        if (at_half && !s) state_nx = IDLE;
        else if (at_last)  state_nx = DATA;
      end
      DATA: begin
        if (mode_q) begin
          if (at_half) shift_en = 1'b1;
        end else begin
          if (at_qtr) h1_en = 1'b1;
          if (at_3qtr) begin
            if (h1 == s) begin
              err_set  = 1'b1;
              state_nx = IDLE;
            end else begin
              shift_en  = 1'b1;
              shift_bit = h1;
            end
          end
        end
        // A code violation on the same cycle as the wrap (T=4) wins
        if (at_last && state_nx == DATA) begin
          if (bitidx == 3'd0) state_nx = STOP;
          else                bit_dec  = 1'b1;
        end
      end
      STOP: begin
        // Leave at mid-bit so a start bit directly after the stop bit is seen
        if (at_half) begin
          state_nx = IDLE;
          if (!s) msg_load = 1'b1;
          else    err_set  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bit-phase counter, bit index, shift register and output strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      pl_q      <= 3'd0;
      mode_q    <= 1'b0;
      bitidx    <= 3'd0;
      sh        <= 5'd0;
      h1        <= 1'b0;
      Msg       <= 5'd0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else if (init) begin
      cnt       <= '0;
      pl_q      <= 3'd0;
      mode_q    <= 1'b0;
      bitidx    <= 3'd0;
      sh        <= 5'd0;
      h1        <= 1'b0;
      Msg       <= 5'd0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= msg_load;
      frame_err <= err_set;
      if (msg_load) Msg <= sh;
      if (start_det) begin
        pl_q   <= PL;
        mode_q <= Mode;
        cnt    <= '0;
      end else if (state != IDLE) begin
        cnt <= at_last ? '0 : cnt + CW'(1);
      end
      if (state == START && at_last) bitidx <= 3'd4;
      else if (bit_dec)              bitidx <= bitidx - 3'd1;
      if (h1_en)    h1 <= s;
      if (shift_en) sh <= {sh[3:0], shift_bit};
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/msg_receiver.md
Name: msg_receiver

Overview:
Serial receive stage directly downstream of the message transmitter datapath. It samples the transmitter's single-bit serial line, detects frames and recovers the 5-bit message in either NRZ or Manchester mode. It uses the same PL bit-length code and the same init convention as the transmitter. The recovered message is presented with a one-cycle valid strobe. Malformed frames are reported as one-cycle error strobes.

Parameters:
BASE_CYCLES, 16, clocks per bit when PL=0; the bit period is T = BASE_CYCLES << PL. Must be a power of two and at least 4.
CW, $clog2(BASE_CYCLES*128), width of the bit-phase counter (derived; do not override).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
init  input  1  synchronous clear. Aborts any frame; outputs go to their reset values.
in  input  1  serial line from the transmitter; idles low; asynchronous to frame timing.
PL  input  3  bit-length code, T = BASE_CYCLES << PL.
Mode  input  1  1 = NRZ, 0 = Manchester.
Msg  output  5  last correctly received message.
valid  output  1  one-cycle strobe; Msg updated in this same cycle.
frame_err  output  1  one-cycle strobe on a bad stop bit or a Manchester code violation.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst) and init give the same result: Msg=0, valid=0, frame_err=0, busy=0, state=IDLE, counters=0, synchroniser flops=0.
- Input path:
  - 2-flop synchroniser gives s; a third flop gives s_d.
  - All decisions use s. The latency from a pin change to s is 2 clocks.
- Frame format (decided):
  - Start bit: high for T.
  - Five data bits, MSB first (Msg[4] first), each lasting T.
  - Stop bit: low for T.
  - NRZ data bit = line level.
  - Manchester '1' = high for T/2 then low for T/2. Manchester '0' = low then high.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on s=1 and s_d=0, latch PL into pl_q and Mode into mode_q, clear cnt, go to START. Changes to PL or Mode after this point are ignored until the next IDLE.
  - In START, DATA and STOP, cnt increments each clock and wraps from T-1 to 0. When it wraps in START or DATA, advance the bit or state.
  - START: sample s at cnt==T/2.
    - s=0: treat as a glitch and return to IDLE. No strobe.
    - s=1: continue until cnt wraps, then go to DATA with bitidx=4.
  - DATA, NRZ: shift s into sh at cnt==T/2.
  - DATA, Manchester:
    - Capture h1=s at cnt==T/4 and h2=s at cnt==3T/4.
    - At the 3T/4 sample, if h1==h2: pulse frame_err and go to IDLE. Msg is unchanged.
    - Otherwise shift h1 into sh.
  - DATA exit: after bitidx 0 completes (cnt wraps), go to STOP.
  - STOP: sample s at cnt==T/2.
    - s=0: next cycle Msg<=sh and valid=1; go to IDLE.
    - s=1: next cycle frame_err=1; go to IDLE; Msg unchanged.
  - Leaving STOP at mid-bit is intentional so a back-to-back start edge is not missed.
- valid and frame_err are never high in the same cycle. Each is high for exactly one clock.
- A rising edge on s in any state other than IDLE is ignored.
- rst or init mid-frame aborts immediately: no valid, no frame_err, Msg cleared to 0.
- Boundary rule: PL=7 gives T=BASE_CYCLES*128. cnt must not overflow, which CW guarantees.
- Latency: valid is asserted 2 + T + 5T + T/2 + 1 clocks after the rising edge of the start bit at the pin.

Test Plan:
- BASE_CYCLES=4, PL=0, Mode=1; drive frame 11011 (start 1, data 1,1,0,1,1, stop 0), 4 clocks per bit -> valid for one cycle at 2+4+20+2+1=29 clocks after the start edge; Msg=5'b11011; frame_err=0.
- PL=2 (T=16), Mode=0; Manchester frame 00110 -> Msg=5'b00110 with one valid pulse. Change PL to 0 mid-frame -> result unchanged.
- NRZ; high pulse of 1 bit-time/4 on an idle line -> START rejects it at mid-bit; no valid, no frame_err; busy returns to 0.
- NRZ frame with stop bit held high -> frame_err pulses once; Msg keeps its previous value.
- Manchester, third data bit sent as constant high for the full T -> frame_err at that bit's 3T/4 sample; FSM returns to IDLE; the following good frame 10101 decodes correctly.
- Assert rst for 3 cycles, and separately init for 1 cycle, during DATA of an NRZ frame -> outputs go to 0 immediately, no strobe; two back-to-back frames (01010 then 10001, no idle gap beyond the stop bit) then give two valid pulses with correct Msg values.
